// File: rtl/mux_scan_serializer.sv
// Registered N:1 bit selector with an optional scan mode that captures the input word
// and shifts it out one bit per clock, ascending or descending, with busy/done handshake.
module mux_scan_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    input  logic [SEL_W-1:0] S,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic             Out1,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    localparam logic [SEL_W-1:0] LastIdx    = SEL_W'(WIDTH - 1);
    localparam logic [1:0]       ModeStatic = 2'b00;
    localparam logic [1:0]       ModeAsc    = 2'b01;
    localparam logic [1:0]       ModeDesc   = 2'b10;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_shadow, w_shadow_d;
    logic             r_desc, w_desc_d;
    logic             r_out, w_out_d;
    logic [SEL_W-1:0] r_sel, w_sel_d;
    logic             r_busy, w_busy_d;
    logic             r_done, w_done_d;

    logic             w_scan_go;
    logic             w_s_in_range;
    logic [SEL_W-1:0] w_end_sel;
    logic [SEL_W-1:0] w_sel_step;
    logic             w_at_end;

    assign w_scan_go    = (r_state == StIdle) && start && ((mode == ModeAsc) || (mode == ModeDesc));
    assign w_s_in_range = 32'(S) < WIDTH;
    assign w_end_sel    = r_desc ? '0 : LastIdx;
    assign w_at_end     = (r_sel == w_end_sel);
    assign w_sel_step   = r_desc ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_shadow <= '0;
            r_desc   <= 1'b0;
            r_out    <= 1'b0;
            r_sel    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_shadow <= w_shadow_d;
            r_desc   <= w_desc_d;
            r_out    <= w_out_d;
            r_sel    <= w_sel_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_scan_go) w_state_d = StScan;
            StScan:  if (w_at_end) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_shadow_d = r_shadow;
        w_desc_d   = r_desc;
        w_out_d    = r_out;
        w_sel_d    = r_sel;
        w_busy_d   = 1'b0;
        w_done_d   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (mode == ModeStatic) begin
                    w_sel_d = S;
                    w_out_d = w_s_in_range ? I[S] : 1'b0;
                end else if (w_scan_go) begin
                    w_shadow_d = I;
                    w_desc_d   = (mode == ModeDesc);
                    w_busy_d   = 1'b1;
                    if (mode == ModeDesc) begin
                        w_sel_d = LastIdx;
                        w_out_d = I[WIDTH-1];
                    end else begin
                        w_sel_d = '0;
                        w_out_d = I[0];
                    end
                end
            end
            StScan: begin
                // On the last index the outputs simply hold while the FSM drops back to idle.
                if (!w_at_end) begin
                    w_sel_d  = w_sel_step;
                    w_out_d  = r_shadow[w_sel_step];
                    w_busy_d = 1'b1;
                    w_done_d = (w_sel_step == w_end_sel);
                end
            end
            default: begin
                w_busy_d = 1'b0;
            end
        endcase
    end

    assign Out1    = r_out;
    assign cur_sel = r_sel;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: transaction-level reference model checked every cycle,
// directed literal checks, randomized stimulus, and a WIDTH=6 instance for range cases.
module tb_mux_scan_serializer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] I;
    logic [2:0] S;
    logic [1:0] mode;
    logic       start;
    logic       Out1;
    logic [2:0] cur_sel;
    logic       busy;
    logic       done;

    logic [5:0] I6;
    logic [2:0] S6;
    logic [1:0] mode6;
    logic       start6;
    logic       out6;
    logic [2:0] sel6;
    logic       busy6;
    logic       done6;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mux_scan_serializer #(.WIDTH(8), .SEL_W(3)) u_dut (
        .clk(clk), .rst(rst), .I(I), .S(S), .mode(mode), .start(start),
        .Out1(Out1), .cur_sel(cur_sel), .busy(busy), .done(done)
    );

    mux_scan_serializer #(.WIDTH(6), .SEL_W(3)) u_dut6 (
        .clk(clk), .rst(rst), .I(I6), .S(S6), .mode(mode6), .start(start6),
        .Out1(out6), .cur_sel(sel6), .busy(busy6), .done(done6)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted scan becomes a queue of per-cycle output records,
    // ending with one idle record that holds the last bit.
    typedef struct {
        logic b;
        int   idx;
        logic bsy;
        logic dn;
    } ent_t;

    ent_t q[$];
    logic m_valid = 1'b0;
    logic e_out, e_busy, e_done;
    int   e_sel;

    initial begin
        ent_t e;
        int   idx;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                e_out = 1'b0; e_sel = 0; e_busy = 1'b0; e_done = 1'b0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                if (q.size() == 0) begin
                    if (mode == 2'b00) begin
                        e_out = (int'(S) < W) ? I[S] : 1'b0;
                        e_sel = int'(S);
                    end else if ((mode == 2'b01 || mode == 2'b10) && start) begin
                        for (int k = 0; k < W; k++) begin
                            idx = (mode == 2'b01) ? k : W - 1 - k;
                            q.push_back('{b: I[idx], idx: idx, bsy: 1'b1, dn: (k == W - 1)});
                        end
                        idx = (mode == 2'b01) ? W - 1 : 0;
                        q.push_back('{b: I[idx], idx: idx, bsy: 1'b0, dn: 1'b0});
                    end
                    e_busy = 1'b0;
                    e_done = 1'b0;
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    e_out = e.b; e_sel = e.idx; e_busy = e.bsy; e_done = e.dn;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_valid) begin
                chk("model_out", Out1, e_out);
                chk("model_sel", cur_sel, e_sel);
                chk("model_busy", busy, e_busy);
                chk("model_done", done, e_done);
            end
        end
    end

    int asc_exp[8]  = '{1, 0, 1, 0, 0, 1, 1, 1};
    int desc_exp[8] = '{1, 1, 1, 0, 0, 1, 0, 1};
    int desc6[6]    = '{1, 0, 1, 1, 0, 0};

    task automatic scan_check(input logic [1:0] md, input int rst_at, input bit disturb);
        int ndone = 0;
        mode  = md;
        I     = 8'hE5;
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                I     = 8'h00;
            end
            chk("scan_out", Out1, (md == 2'b01) ? asc_exp[k] : desc_exp[k]);
            chk("scan_sel", cur_sel, (md == 2'b01) ? k : 7 - k);
            chk("scan_busy", busy, 1);
            chk("scan_done", done, (k == 7) ? 1 : 0);
            if (done) ndone++;
            if (disturb && k == 3) begin
                start = 1'b1;
                mode  = 2'b10;
            end
            if (disturb && k == 4) start = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_out", Out1, 0);
                chk("rst_sel", cur_sel, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                return;
            end
        end
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("post_out", Out1, 1);
        chk("post_sel", cur_sel, (md == 2'b01) ? 7 : 0);
        chk("done_count", ndone, 1);
    endtask

    initial begin
        rst = 1'b1; I = '0; S = '0; mode = 2'b00; start = 1'b0;
        I6 = '0; S6 = '0; mode6 = 2'b11; start6 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out", Out1, 0);
        chk("reset_sel", cur_sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            mode = 2'b00; I = 8'hE5; S = 3'(k);
            @(negedge clk);
            chk("static_out", Out1, asc_exp[k]);
            chk("static_sel", cur_sel, k);
            chk("static_busy", busy, 0);
            chk("static_done", done, 0);
        end

        scan_check(2'b01, -1, 1'b0);
        scan_check(2'b10, -1, 1'b0);
        mode = 2'b10;
        @(negedge clk);
        chk("desc_hold_out", Out1, 1);
        chk("desc_hold_sel", cur_sel, 0);
        scan_check(2'b01, -1, 1'b1);
        scan_check(2'b01, 4, 1'b0);
        scan_check(2'b01, -1, 1'b0);

        // Narrow instance: out-of-range select, hold mode, and a descending scan.
        mode6 = 2'b00; S6 = 3'd7; I6 = 6'h3F;
        @(negedge clk);
        chk("w6_oor_out", out6, 0);
        chk("w6_oor_sel", sel6, 7);
        S6 = 3'd5;
        @(negedge clk);
        chk("w6_in_out", out6, 1);
        chk("w6_in_sel", sel6, 5);
        S6 = 3'd7;
        @(negedge clk);
        chk("w6_oor2_out", out6, 0);
        mode6 = 2'b11;
        for (int k = 0; k < 3; k++) begin
            I6 = ~I6; S6 = 3'(k);
            @(negedge clk);
            chk("w6_hold_out", out6, 0);
            chk("w6_hold_sel", sel6, 7);
        end
        mode6 = 2'b10; I6 = 6'b101100; start6 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start6 = 1'b0;
            chk("w6_scan_out", out6, desc6[k]);
            chk("w6_scan_sel", sel6, 5 - k);
            chk("w6_scan_busy", busy6, 1);
            chk("w6_scan_done", done6, (k == 5) ? 1 : 0);
        end
        @(negedge clk);
        chk("w6_post_busy", busy6, 0);
        chk("w6_post_out", out6, 0);
        chk("w6_post_sel", sel6, 0);

        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            mode  = 2'($urandom_range(0, 3));
            start = ($urandom_range(0, 2) == 0);
            S     = 3'($urandom);
            I     = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
Parametrised successor to the team's 4:1 select multiplexer. Selects one bit of a WIDTH-bit input word, either statically from a select input or by automatically scanning all channels.
- Static mode is a registered N:1 mux.
- Scan modes capture the word and shift it out one bit per clock, ascending or descending, with a start/busy/done handshake.
- Sits between parallel status/data sources and single-bit serial consumers.

Parameters:
WIDTH, 8, number of input channels (bits of I); legal range 2..256.
SEL_W, 3, width of the select and index fields; must satisfy 2**SEL_W >= WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active high.
I  input  WIDTH  parallel data channels.
S  input  SEL_W  static channel select, used in mode 00.
mode  input  2  00 static, 01 scan ascending, 10 scan descending, 11 hold.
start  input  1  single-cycle request to begin a scan; honoured only in IDLE with mode 01/10.
Out1  output  1  registered selected bit.
cur_sel  output  SEL_W  index of the channel currently driven on Out1.
busy  output  1  high while a scan is in progress.
done  output  1  one-cycle pulse coincident with the last scanned bit on Out1.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; Out1=0, cur_sel=0, busy=0, done=0; shadow register cleared. Reset overrides every other input, including mid-scan; the scan is abandoned with no done pulse.
- FSM states: IDLE, SCAN.
- IDLE, mode 00: each cycle Out1<=I[S] and cur_sel<=S. If S>=WIDTH, Out1<=0 and cur_sel<=S. Latency is 1 clock from I/S to Out1.
- IDLE, mode 11: Out1 and cur_sel hold their values.
- IDLE, mode 01/10 with start=0: Out1 and cur_sel hold their values.
- IDLE, mode 01/10 with start=1:
  - Capture I into the shadow register and latch the mode into the direction flag.
  - Go to SCAN, busy<=1.
  - Same edge: Out1<=I[0] with cur_sel<=0 (ascending), or Out1<=I[WIDTH-1] with cur_sel<=WIDTH-1 (descending).
- start with mode 00/11 is ignored.
- SCAN:
  - Each clock, cur_sel steps by +1 (ascending) or -1 (descending) and Out1<=shadow[cur_sel_next].
  - The last index is WIDTH-1 (ascending) or 0 (descending).
  - done=1 during the cycle Out1 shows the last index. On the following edge: state<=IDLE, busy<=0, done<=0, and Out1/cur_sel hold the last bit.
  - Scan length is exactly WIDTH cycles with busy high; the first bit appears 1 clock after start is sampled.
- While busy, start, mode, S and I are ignored. The shadow register isolates the scan from changes on I. The index never wraps.
- Back-to-back: start asserted in the cycle after busy falls begins a new scan (minimum gap of one IDLE cycle).
- done never asserts outside SCAN. busy and done are registered outputs.

Test Plan:
- Static select: WIDTH=8, mode=00, I=8'hE5, S=0..7 one per cycle -> Out1 sequence 1,0,1,0,0,1,1,1 with 1-clock latency; cur_sel tracks S; busy=0 and done=0 throughout.
- Ascending scan: I=8'hE5, mode=01, start pulse, then I=8'h00 on the next cycle -> Out1=1,0,1,0,0,1,1,1 over 8 cycles (captured value); cur_sel=0..7; busy high 8 cycles; done high only while cur_sel=7.
- Descending scan: I=8'hE5, mode=10, start -> Out1=1,1,1,0,0,1,0,1 over 8 cycles; cur_sel=7..0; done only while cur_sel=0; IDLE afterwards with Out1=1 held.
- Ignored inputs: during an ascending scan, pulse start and switch mode to 10 at cycle 3 -> sequence and length unchanged; exactly one done pulse.
- Reset mid-scan: assert rst at scan cycle 4 -> next edge Out1=0, cur_sel=0, busy=0, no done pulse. A new start after rst deasserts runs a full 8-cycle scan.
- Out-of-range and hold: WIDTH=6, SEL_W=3, mode=00, S=7 -> Out1=0, cur_sel=7. Then mode=11 while I toggles -> Out1 and cur_sel hold.
